// File: rtl/ex_me_skid_if.sv
// EX->ME pipeline link: valid/ready handshake plus the execute-stage result fields.
// The master drives valid and the payload; the slave drives ready.
interface ex_me_skid_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] ALU_result;
  logic [XLEN-1:0] write_data;
  logic [RA_W-1:0] rd;
  logic [1:0]      wb_ctrl;
  logic            we_reg;
  logic            we_mem;
  logic [2:0]      ls_type;
  logic [XLEN-1:0] PC;

  modport master (
    output valid, ALU_result, write_data, rd, wb_ctrl, we_reg, we_mem, ls_type, PC,
    input  ready
  );

  modport slave (
    input  valid, ALU_result, write_data, rd, wb_ctrl, we_reg, we_mem, ls_type, PC,
    output ready
  );
endinterface

// File: rtl/ex_me_skid.sv
// Two-entry EX->ME skid buffer: 1-cycle latency, registered ready_E (no comb path from ready_M).
// Backpressure: the skid entry absorbs one accept while OUT stalls; ready_E drops while it is full.
module ex_me_skid #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  ex_me_skid_if.slave   e_if,
  ex_me_skid_if.master  m_if
);

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] wdata;
    logic [RA_W-1:0] rd;
    logic [1:0]      wb_ctrl;
    logic            we_reg;
    logic            we_mem;
    logic [2:0]      ls_type;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t r_out;
  entry_t r_skid;
  entry_t w_in;
  logic   r_out_vld;
  logic   r_skid_vld;
  logic   r_ready_e;

  logic   w_acc;
  logic   w_cons;
  logic   w_out_free;
  logic   w_load_out_skid;
  logic   w_load_out_in;
  logic   w_load_skid;
  logic   w_out_vld_nxt;
  logic   w_skid_vld_nxt;

  assign w_in = '{alu:     e_if.ALU_result,
                  wdata:   e_if.write_data,
                  rd:      e_if.rd,
                  wb_ctrl: e_if.wb_ctrl,
                  we_reg:  e_if.we_reg,
                  we_mem:  e_if.we_mem,
                  ls_type: e_if.ls_type,
                  pc:      e_if.PC};

  assign w_acc      = e_if.valid & r_ready_e;
  assign w_cons     = r_out_vld & m_if.ready;
  assign w_out_free = w_cons | ~r_out_vld;

  // A held skid entry always has priority for OUT; accept cannot coincide since ready_E is low then.
  assign w_load_out_skid = w_out_free & r_skid_vld;
  assign w_load_out_in   = w_out_free & ~r_skid_vld & w_acc;
  assign w_load_skid     = ~w_out_free & w_acc;
  assign w_out_vld_nxt   = w_out_free ? (r_skid_vld | w_acc) : 1'b1;
  assign w_skid_vld_nxt  = w_load_skid | (r_skid_vld & ~w_out_free);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_ready_e  <= 1'b1;
    end else if (flush) begin
      r_out_vld      <= 1'b0;
      r_skid_vld     <= 1'b0;
      r_ready_e      <= 1'b1;
      r_out.we_reg   <= 1'b0;
      r_out.we_mem   <= 1'b0;
      r_skid.we_reg  <= 1'b0;
      r_skid.we_mem  <= 1'b0;
    end else begin
      r_out_vld  <= w_out_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      r_ready_e  <= ~w_skid_vld_nxt;
      if (w_load_out_skid) begin
        r_out <= r_skid;
      end else if (w_load_out_in) begin
        r_out <= w_in;
      end
      if (w_load_skid) begin
        r_skid <= w_in;
      end
    end
  end

  assign e_if.ready      = r_ready_e;
  assign m_if.valid      = r_out_vld;
  assign m_if.ALU_result = r_out.alu;
  assign m_if.write_data = r_out.wdata;
  assign m_if.rd         = r_out.rd;
  assign m_if.wb_ctrl    = r_out.wb_ctrl;
  assign m_if.ls_type    = r_out.ls_type;
  assign m_if.PC         = r_out.pc;
  // Enables are qualified so a stale or flushed entry can never write.
  assign m_if.we_reg     = r_out.we_reg & r_out_vld;
  assign m_if.we_mem     = r_out.we_mem & r_out_vld;

endmodule
